psum_accumulator: RTL and testbench
===================================

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, which is the output element width (matches the ReLu input width).
REQ-002 SHALL have parameter PSUM_WIDTH, default 32, which is the width of the input partial sums and of the accumulators.
REQ-003 SHALL have parameter LENGTH, default 64, which is the number of lanes per vector.
REQ-004 SHALL have parameter SHIFT, default 0, which is the arithmetic right shift applied before output narrowing.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: the partial-sum beat is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block can accept a beat.
REQ-009 SHALL have port in_first, input, 1 bit: this beat starts a group and loads rather than adds.
REQ-010 SHALL have port in_last, input, 1 bit: this beat ends a group and triggers output.
REQ-011 SHALL have port In[0:LENGTH-1], input, PSUM_WIDTH bits each: signed two's-complement partial sums from the systolic array.
REQ-012 SHALL have port out_valid, output, 1 bit: the Out vector is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: the downstream stage (ReLu) accepts Out.
REQ-014 SHALL have port Out[0:LENGTH-1], output, DATA_WIDTH bits each: the signed, saturated result vector.
REQ-015 SHALL have port out_sat, output, 1 bit: at least one lane saturated somewhere in this group.

Function
REQ-016 SHALL implement a 2-state FSM: ACCUM (in_ready=1, out_valid=0) and OUTPUT (in_ready=0, out_valid=1).
REQ-017 SHALL accept a beat only when in_valid && in_ready are both 1 on a rising clk edge; in_valid while in_ready=0 SHALL be ignored with no state change.
REQ-018 SHALL, on an accepted beat with in_first=1, load acc[i] = In[i]; with in_first=0, set acc[i] = sat_PSUM(acc[i] + In[i]).
REQ-019 SHALL make sat_PSUM clamp to [-2^(PSUM_WIDTH-1), 2^(PSUM_WIDTH-1)-1], with no wrap-around.
REQ-020 SHALL, on an accepted beat with in_last=1, register Out[i] = sat_DATA(updated acc[i] >>> SHIFT) and move to OUTPUT; out_valid SHALL go high the cycle after the accepting edge (1-cycle latency).
REQ-021 SHALL make sat_DATA clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; the shift SHALL be arithmetic (sign-preserving, rounds toward -inf).
REQ-022 SHALL treat in_first=1 and in_last=1 on the same beat as a single-tile group: Out = sat_DATA(In >>> SHIFT).
REQ-023 SHALL set out_sat if any lane clamps in sat_PSUM or sat_DATA during the group, clear it on an in_first beat (then OR in that beat's saturation), and register it alongside Out.
REQ-024 SHALL hold Out and out_sat stable in OUTPUT until out_valid && out_ready; out_valid SHALL NOT drop without a handshake.
REQ-025 SHALL, on the output handshake edge, clear all acc to 0 and return to ACCUM so that in_ready=1 in the next cycle; Out SHALL keep its last value.
REQ-026 SHALL treat a beat with in_first=0 as the start of a new group added onto the cleared acc=0 (equivalent to a load).
REQ-027 SHALL provide no bypass: in_ready SHALL be 0 in the handshake cycle itself.
REQ-028 SHALL update all lanes in lockstep; lanes SHALL be independent (no cross-lane arithmetic).

Reset
REQ-029 SHALL, while reset=1 at a clk edge, set state to ACCUM, all acc=0, all Out=0, out_valid=0, and out_sat=0.
REQ-030 SHALL hold in_ready at 0 while reset=1; beats presented during reset SHALL be ignored.
REQ-031 SHALL, on reset mid-group or in OUTPUT, discard the partial group or pending output with no output emitted.

Verification
REQ-032 SHALL cover: reset held 2 cycles -> out_valid=0, all Out=0x0000, in_ready=0 during reset, then in_ready=1 on the first cycle after.
REQ-033 SHALL cover: single beat, first=last=1, In[0]=5, In[1]=-3 -> next cycle out_valid=1, Out[0]=0x0005, Out[1]=0xFFFD, out_sat=0.
REQ-034 SHALL cover: 3 beats with In[0]=100, 200, -50 (first on beat 1, last on beat 3) -> Out[0]=0x00FA, and in_ready=0 while out_valid=1.
REQ-035 SHALL cover: 2 beats with In[0]=30000 and In[1]=-20000 on each beat -> Out[0]=0x7FFF, Out[1]=0x8000, out_sat=1.
REQ-036 SHALL cover: out_ready=0 for 5 cycles with in_valid=1 -> Out stable, beats ignored; out_ready=1 -> handshake, in_ready=1 the next cycle, a following single beat 7 gives Out[0]=0x0007.
REQ-037 SHALL cover: 2 beats accepted, then reset for 1 cycle, then a single beat In[0]=7 with first=last=1 -> Out[0]=0x0007 (pre-reset sums lost); also In[0]=0x7FFFFFF0 followed by +0x100 -> acc clamps at 0x7FFFFFFF, Out[0]=0x7FFF, out_sat=1.

Source files
------------

// File: rtl/psum_accumulator.sv
// Accumulates signed partial-sum vectors over a group of beats, then emits one
// shifted, saturated DATA_WIDTH vector and holds it until downstream takes it.
module psum_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int PSUM_WIDTH = 32,
  parameter int LENGTH     = 64,
  parameter int SHIFT      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [PSUM_WIDTH-1:0] In [0:LENGTH-1],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Out [0:LENGTH-1],
  output logic                  out_sat
);

  typedef enum logic {ACCUM, OUTPUT} state_e;

  localparam logic [PSUM_WIDTH-1:0] PSUM_MAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
  localparam logic [PSUM_WIDTH-1:0] PSUM_MIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] DATA_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] DATA_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_e                state_q;
  logic [PSUM_WIDTH-1:0] acc_q [0:LENGTH-1];
  logic [PSUM_WIDTH-1:0] acc_d [0:LENGTH-1];
  logic [DATA_WIDTH-1:0] out_q [0:LENGTH-1];
  logic [DATA_WIDTH-1:0] out_d [0:LENGTH-1];
  logic [LENGTH-1:0]     psum_sat;
  logic [LENGTH-1:0]     data_sat;
  logic                  grp_sat_q;
  logic                  grp_sat_d;
  logic                  out_sat_q;

  // in_ready is forced low during reset so beats presented then are dropped.
  assign in_ready  = (state_q == ACCUM) && !reset;
  assign out_valid = (state_q == OUTPUT);
  assign Out       = out_q;
  assign out_sat   = out_sat_q;

  for (genvar i = 0; i < LENGTH; i++) begin : g_lane
    logic [PSUM_WIDTH-1:0] base;
    logic [PSUM_WIDTH:0]   sum_ext;
    logic [PSUM_WIDTH-1:0] shifted;

    // A first beat adds onto zero, which makes it a plain load.
    assign base        = in_first ? '0 : acc_q[i];
    assign sum_ext     = {base[PSUM_WIDTH-1], base} + {In[i][PSUM_WIDTH-1], In[i]};
    assign psum_sat[i] = sum_ext[PSUM_WIDTH] ^ sum_ext[PSUM_WIDTH-1];
    assign acc_d[i]    = psum_sat[i] ? (sum_ext[PSUM_WIDTH] ? PSUM_MIN : PSUM_MAX)
                                     : sum_ext[PSUM_WIDTH-1:0];
    assign shifted     = $signed(acc_d[i]) >>> SHIFT;
    // Fits in DATA_WIDTH only if all bits above the output sign bit match it.
    assign data_sat[i] = !((&shifted[PSUM_WIDTH-1:DATA_WIDTH-1]) ||
                           !(|shifted[PSUM_WIDTH-1:DATA_WIDTH-1]));
    assign out_d[i]    = data_sat[i] ? (shifted[PSUM_WIDTH-1] ? DATA_MIN : DATA_MAX)
                                     : shifted[DATA_WIDTH-1:0];
  end

  assign grp_sat_d = (in_first ? 1'b0 : grp_sat_q) | (|psum_sat);

  // NOTE: all state uses non-blocking assignments so every lane and the FSM
  // see the same pre-edge values; the accumulator array is reset explicitly
  // because a partial group must never leak across a reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ACCUM;
      grp_sat_q <= 1'b0;
      out_sat_q <= 1'b0;
      for (int i = 0; i < LENGTH; i++) begin
        acc_q[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            acc_q <= acc_d;
            if (in_last) begin
              out_q     <= out_d;
              out_sat_q <= grp_sat_d | (|data_sat);
              grp_sat_q <= 1'b0;
              state_q   <= OUTPUT;
            end else begin
              grp_sat_q <= grp_sat_d;
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            for (int i = 0; i < LENGTH; i++) acc_q[i] <= '0;
            state_q <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: an integer reference model pushes expected
// output vectors to a queue, popped and compared when out_valid rises.
module tb_psum_accumulator;
  localparam int DW  = 16;
  localparam int PW  = 32;
  localparam int LEN = 64;
  localparam int SH  = 0;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, in_first, in_last;
  logic          out_valid, out_ready, out_sat;
  logic [PW-1:0] in_vec  [0:LEN-1];
  logic [DW-1:0] out_vec [0:LEN-1];

  always #5 clk = ~clk;

  psum_accumulator #(.DATA_WIDTH(DW), .PSUM_WIDTH(PW), .LENGTH(LEN), .SHIFT(SH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
    .In(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .Out(out_vec), .out_sat(out_sat)
  );

  typedef struct packed {
    logic                   sat;
    logic [LEN-1:0][DW-1:0] o;
  } exp_t;

  exp_t   sb[$];
  exp_t   last_exp;
  longint macc [LEN];
  logic   mgrp;
  int     n_total = 0;
  int     n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint clamp(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LEN; i++) macc[i] = 0;
    mgrp = 1'b0;
  endtask

  // Lanes 0/1 carry the directed values; the rest get a lane-dependent pattern.
  task automatic set_in(input longint v0, input longint v1);
    for (int i = 0; i < LEN; i++) begin
      longint v;
      v = (i == 0) ? v0 : ((i == 1) ? v1 : longint'(i * 37 - 1000));
      in_vec[i] = v[PW-1:0];
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic beat(input logic first, input logic last, input longint v0, input longint v1);
    exp_t e;
    set_in(v0, v1);
    in_first = first;
    in_last  = last;
    in_valid = 1'b1;
    check("in_ready_before_beat", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    if (first) mgrp = 1'b0;
    e = '0;
    for (int i = 0; i < LEN; i++) begin
      longint x, s, d;
      x = longint'($signed(in_vec[i]));
      s = first ? x : macc[i] + x;
      macc[i] = clamp(s, PW);
      if (macc[i] != s) mgrp = 1'b1;
      if (last) begin
        d = clamp(macc[i] >>> SH, DW);
        if (d != (macc[i] >>> SH)) mgrp = 1'b1;
        e.o[i] = d[DW-1:0];
      end
    end
    if (last) begin
      e.sat = mgrp;
      sb.push_back(e);
      mgrp = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_out();
    for (int k = 0; k < 20 && out_valid !== 1'b1; k++) @(negedge clk);
    check("out_valid_rise", {63'd0, out_valid}, 64'd1);
    check("sb_nonempty", {63'd0, (sb.size() > 0)}, 64'd1);
    if (sb.size() > 0) begin
      last_exp = sb.pop_front();
      for (int i = 0; i < LEN; i++)
        check($sformatf("out[%0d]", i), {48'd0, out_vec[i]}, {48'd0, last_exp.o[i]});
      check("out_sat", {63'd0, out_sat}, {63'd0, last_exp.sat});
    end
    check("in_ready_in_output", {63'd0, in_ready}, 64'd0);
  endtask

  // Stalls `hold` cycles with junk beats offered, then completes the handshake.
  task automatic handshake(input int hold);
    for (int k = 0; k < hold; k++) begin
      set_in(1234, -1234);
      in_first = 1'b1;
      in_last  = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      check("stall_out_valid", {63'd0, out_valid}, 64'd1);
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      check("stall_out0", {48'd0, out_vec[0]}, {48'd0, last_exp.o[0]});
      check("stall_out1", {48'd0, out_vec[1]}, {48'd0, last_exp.o[1]});
      check("stall_sat", {63'd0, out_sat}, {63'd0, last_exp.sat});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("hs_in_ready_zero", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    for (int i = 0; i < LEN; i++) macc[i] = 0;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_out_valid", {63'd0, out_valid}, 64'd0);
    check("post_hs_in_ready", {63'd0, in_ready}, 64'd1);
    check("post_hs_out0_kept", {48'd0, out_vec[0]}, {48'd0, last_exp.o[0]});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    reset     = 1'b1;
    out_ready = 1'b0;
    in_first  = 1'b1;
    in_last   = 1'b1;
    in_valid  = 1'b1;
    set_in(999, 999);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("after_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("after_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("after_rst_out_sat", {63'd0, out_sat}, 64'd0);
    for (int i = 0; i < LEN; i++) check($sformatf("rst_out[%0d]", i), {48'd0, out_vec[i]}, 64'd0);

    // Single-tile group.
    beat(1'b1, 1'b1, 5, -3);
    expect_out();
    check("c1_out0", {48'd0, out_vec[0]}, 64'h0005);
    check("c1_out1", {48'd0, out_vec[1]}, 64'hFFFD);
    check("c1_sat", {63'd0, out_sat}, 64'd0);
    handshake(0);

    // Three-beat group.
    beat(1'b1, 1'b0, 100, 1);
    beat(1'b0, 1'b0, 200, 2);
    beat(1'b0, 1'b1, -50, 3);
    expect_out();
    check("c2_out0", {48'd0, out_vec[0]}, 64'h00FA);
    handshake(0);

    // Output-width saturation both ways, then a 5-cycle stall.
    beat(1'b1, 1'b0, 30000, -20000);
    beat(1'b0, 1'b1, 30000, -20000);
    expect_out();
    check("c3_out0", {48'd0, out_vec[0]}, 64'h7FFF);
    check("c3_out1", {48'd0, out_vec[1]}, 64'h8000);
    check("c3_sat", {63'd0, out_sat}, 64'd1);
    handshake(5);
    beat(1'b1, 1'b1, 7, 0);
    expect_out();
    check("c4_out0", {48'd0, out_vec[0]}, 64'h0007);
    check("c4_sat_cleared", {63'd0, out_sat}, 64'd0);
    handshake(0);

    // Reset mid-group discards the partial sums.
    beat(1'b1, 1'b0, 1000, 1000);
    beat(1'b0, 1'b0, 1000, 1000);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    reset = 1'b0;
    #1;
    model_clear();
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    beat(1'b1, 1'b1, 7, 0);
    expect_out();
    check("c5_out0", {48'd0, out_vec[0]}, 64'h0007);
    handshake(0);

    // Accumulator saturation, positive then negative.
    beat(1'b1, 1'b0, 64'sh7FFFFFF0, -64'sh7FFFFFF0);
    beat(1'b0, 1'b1, 64'sh100, -64'sh100);
    expect_out();
    check("c6_out0", {48'd0, out_vec[0]}, 64'h7FFF);
    check("c6_out1", {48'd0, out_vec[1]}, 64'h8000);
    check("c6_sat", {63'd0, out_sat}, 64'd1);
    handshake(2);

    // A group opened without in_first adds onto the cleared accumulators.
    beat(1'b0, 1'b1, 9, -9);
    expect_out();
    check("c7_out0", {48'd0, out_vec[0]}, 64'h0009);
    check("c7_out1", {48'd0, out_vec[1]}, 64'hFFF7);
    check("c7_sat", {63'd0, out_sat}, 64'd0);
    handshake(0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
